// File: rtl/or_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// or_rr_arbiter_pkg
//   Shared definitions for the round-robin arbiter slice: FSM state encodings,
//   default sizing constants and a small modulo-N increment helper.
// -----------------------------------------------------------------------------
package or_rr_arbiter_pkg;

   // Encodings are fixed so traces stay readable across blocks that share them.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;

   localparam int DEF_N        = 4;
   localparam int DEF_IDW      = 2;
   localparam int DEF_MAX_HOLD = 8;

   // Next index after idx, wrapping at n (n need not be a power of two).
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/or_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// or_rr_arbiter_if
//   Request/grant bundle between the requesting blocks and the arbiter.
//   req      : level request vector, one bit per requester
//   grant    : registered one-hot grant
//   owner    : index of the granted requester (valid while busy)
//   busy     : a grant is active
//   timeout  : one-cycle pulse when a grant was revoked for holding too long
//   master   : requester side;  slave : arbiter side
// -----------------------------------------------------------------------------
interface or_rr_arbiter_if
   import or_rr_arbiter_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int IDW = DEF_IDW
);
   logic [N-1:0]   req;
   logic [N-1:0]   grant;
   logic [IDW-1:0] owner;
   logic           busy;
   logic           timeout;

   modport master (
      output req,
      input  grant, owner, busy, timeout
   );

   modport slave (
      input  req,
      output grant, owner, busy, timeout
   );
endinterface

// File: rtl/or_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// or_rr_arbiter_rr_pick
//   Combinational rotating priority encoder. Returns the first set bit of req
//   scanning ptr, ptr+1, ... wrapping modulo N.
//   req  : request vector
//   ptr  : index holding highest priority
//   any  : at least one request present
//   idx  : winning index (0 when any=0)
// -----------------------------------------------------------------------------
module or_rr_arbiter_rr_pick
   import or_rr_arbiter_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int IDW = DEF_IDW
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           any,
   output logic [IDW-1:0] idx
);

   // Scan from the lowest-priority offset up to the highest so the last hit
   // written is the one closest to ptr.
   always_comb begin
      int             j;
      logic [IDW-1:0] jj;
      any = |req;
      idx = '0;
      j   = 0;
      jj  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         jj = IDW'(j);
         if (req[jj]) idx = jj;
      end
   end

endmodule

// File: rtl/or_rr_arbiter.sv
// -----------------------------------------------------------------------------
// or_rr_arbiter
//   Round-robin arbiter sharing one gated datapath among N requesters.
//   One grant at a time, held while the owner keeps requesting, revoked after
//   MAX_HOLD consecutive cycles (0 = never). Every release is followed by a
//   single idle-grant cycle so the shared path can turn around.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : request/grant bundle (slave side), all outputs registered
// -----------------------------------------------------------------------------
module or_rr_arbiter
   import or_rr_arbiter_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int IDW      = DEF_IDW,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic           clk,
   input  logic           rst_n,
   or_rr_arbiter_if.slave bus
);

   // Wide enough to reach MAX_HOLD; with MAX_HOLD=0 it only saturates.
   localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

   arb_state_e     state, state_n;
   logic [IDW-1:0] ptr, ptr_n;
   logic [HCW-1:0] hold_cnt, hold_n;
   logic [N-1:0]   grant_q, grant_n;
   logic [IDW-1:0] owner_q, owner_n;
   logic           busy_q, busy_n;
   logic           tmo_q, tmo_n;

   logic           pick_any;
   logic [IDW-1:0] pick_idx;

   or_rr_arbiter_rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .req (bus.req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         grant_q  <= '0;
         owner_q  <= '0;
         busy_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
         grant_q  <= grant_n;
         owner_q  <= owner_n;
         busy_q   <= busy_n;
         tmo_q    <= tmo_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      grant_n = grant_q;
      owner_n = owner_q;
      busy_n  = busy_q;
      tmo_n   = 1'b0;

      unique case (state)
         ST_IDLE, ST_GAP: begin
            grant_n = '0;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
            if (pick_any) begin
               grant_n           = '0;
               grant_n[pick_idx] = 1'b1;
               owner_n           = pick_idx;
               busy_n            = 1'b1;
               hold_n            = HCW'(1);
               state_n           = ST_GRANT;
            end
         end

         ST_GRANT: begin
            // A voluntary drop wins over the hold limit, so no timeout then.
            if (!bus.req[owner_q]) begin
               grant_n = '0;
               busy_n  = 1'b0;
               ptr_n   = IDW'(wrap_inc(int'(owner_q), N));
               state_n = ST_GAP;
            end else if (MAX_HOLD != 0 && hold_cnt == HCW'(MAX_HOLD)) begin
               grant_n = '0;
               busy_n  = 1'b0;
               tmo_n   = 1'b1;
               ptr_n   = IDW'(wrap_inc(int'(owner_q), N));
               state_n = ST_GAP;
            end else if (hold_cnt != '1) begin
               hold_n = hold_cnt + 1'b1;
            end
         end

         default: begin
            grant_n = '0;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
         end
      endcase
   end

   assign bus.grant   = grant_q;
   assign bus.owner   = owner_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = tmo_q;

endmodule

// File: tb/tb_or_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_or_rr_arbiter
//   Directed bench for or_rr_arbiter with N=4, MAX_HOLD=8. Outputs are sampled
//   1 time unit after each rising edge; req is changed at the same point.
// -----------------------------------------------------------------------------
module tb_or_rr_arbiter;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   or_rr_arbiter_if #(.N(4), .IDW(2)) bus ();

   or_rr_arbiter #(.N(4), .IDW(2), .MAX_HOLD(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int g, input int o,
                          input int b, input int t);
      chk({tag, ".grant"}, int'(bus.grant), g);
      if (b != 0) chk({tag, ".owner"}, int'(bus.owner), o);
      chk({tag, ".busy"}, int'(bus.busy), b);
      chk({tag, ".timeout"}, int'(bus.timeout), t);
   endtask

   // Eight full grant cycles, then the revoke cycle with its timeout pulse.
   task automatic hold_run(input string tag, input int g, input int o);
      for (int i = 0; i < 8; i++) begin
         chk_out(tag, g, o, 1, 0);
         step();
      end
      chk_out({tag, ".revoke"}, 0, 0, 0, 1);
      step();
   endtask

   // Structural invariants on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("onehot", int'($countones(bus.grant) <= 1), 1);
         chk("busy_vs_grant", int'(bus.busy), int'(bus.grant != 0));
         if (bus.busy) chk("owner_vs_grant", int'(bus.grant), 1 << bus.owner);
      end
   end

   initial begin
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      bus.req = '0;

      // Reset state
      #2;
      chk_out("reset", 0, 0, 0, 0);
      chk("reset.owner", int'(bus.owner), 0);
      step();
      rst_n = 1'b1;
      step();
      chk_out("idle", 0, 0, 0, 0);

      // Single request from idle, then drop: gap, then idle
      bus.req = 4'b0001;
      step();
      chk_out("single", 1, 0, 1, 0);
      step();
      chk_out("single.hold", 1, 0, 1, 0);
      bus.req = 4'b0000;
      step();
      chk_out("single.gap", 0, 0, 0, 0);
      step();
      chk_out("single.idle", 0, 0, 0, 0);

      // ptr is now 1: req 0010 wins; then async reset mid-grant
      bus.req = 4'b0010;
      step();
      chk_out("pre_rst", 2, 1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async.grant", int'(bus.grant), 0);
      chk("async.busy", int'(bus.busy), 0);
      chk("async.owner", int'(bus.owner), 0);
      bus.req = 4'b1111;
      step();
      rst_n = 1'b1;
      step();

      // Rotation with 1111: each owner holds 2 cycles, drops, re-raises in gap
      for (int k = 0; k < 5; k++) begin
         chk_out($sformatf("rot%0d.c1", k), 1 << (k % 4), k % 4, 1, 0);
         step();
         chk_out($sformatf("rot%0d.c2", k), 1 << (k % 4), k % 4, 1, 0);
         bus.req = (k == 4) ? 4'b0000 : (4'b1111 & ~(4'b0001 << (k % 4)));
         step();
         chk_out($sformatf("rot%0d.gap", k), 0, 0, 0, 0);
         if (k != 4) bus.req = 4'b1111;
         step();
      end
      chk_out("rot.idle", 0, 0, 0, 0);

      // ptr is 1: single requester 2 held beyond MAX_HOLD
      bus.req = 4'b0100;
      step();
      hold_run("solo", 4, 2);
      chk_out("solo.regrant", 4, 2, 1, 0);
      bus.req = 4'b0000;
      step();
      chk_out("solo.rel", 0, 0, 0, 0);
      step();

      // ptr is 3: req 0101 -> owner 0, timeout, owner 2, timeout, owner 0
      bus.req = 4'b0101;
      step();
      hold_run("pair0", 1, 0);
      hold_run("pair2", 4, 2);

      // Owner 0 drops exactly in its 8th cycle: plain release, no timeout
      for (int i = 0; i < 8; i++) begin
         chk_out("edge", 1, 0, 1, 0);
         if (i == 7) bus.req = 4'b0100;
         step();
      end
      chk_out("edge.rel", 0, 0, 0, 0);
      step();
      chk_out("edge.next", 4, 2, 1, 0);
      bus.req = 4'b0000;
      step();
      chk_out("edge.drop", 0, 0, 0, 0);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
